zuart_download_ram: RTL and testbench
=====================================

# zuart_download_ram

Receive-side counterpart of the UART upload path: parses the framed PulseCounter stream (sync 55 AA, length 00 3C, 60 big-endian 16-bit words, 16-bit block-cumulative checksum) arriving from the UART receiver. It writes each word into BlockRAM through a request/done handshake and validates framing, length and checksum. A rejected frame rolls the write pointer and checksum back so that the frame's slot is overwritten by the next frame. It sits between the UART module's byte-strobe outputs and a BlockRAM write port.

## Interface
- WORDS_PER_FRAME, 60, data words per frame; also the required length field value.
- FRAMES_PER_BLOCK, 50, good frames per block; the block spans WORDS_PER_FRAME*FRAMES_PER_BLOCK = 3000 words.
- TIMEOUT_CYC, 100000, maximum iClk cycles allowed between bytes inside a frame.
- iClk  in  1  system clock; all logic is on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iEn  in  1  block enable; low acts as a synchronous soft reset.
- iRxData  in  8  received byte; valid only while iRxDone=1.
- iRxDone  in  1  one-cycle strobe, one per received byte.
- oBlockRAM_WrReq  out  1  write request; held high until acknowledged.
- oBlockRAM_WrAddr  out  12  write address, 0..2999.
- oBlockRAM_WrData  out  16  write data.
- iBlockRAM_WrDone  in  1  write acknowledge; the write completes in the cycle this is sampled high.
- oFrameDone  out  1  one-cycle pulse: frame accepted.
- oFrameErr  out  1  one-cycle pulse: frame rejected.
- oErrCode  out  2  last error: 0 none, 1 length, 2 checksum, 3 timeout/overrun; sticky.
- oBlockDone  out  1  one-cycle pulse after FRAMES_PER_BLOCK good frames.
- oBusy  out  1  high from a valid 55 AA until the frame is accepted or rejected.

## Operation
- States: HUNT55, HUNTAA, LENH, LENL, DATH, DATL, WRITE, CHKH, CHKL.
- Bytes are consumed only in cycles where iRxDone=1.
- HUNT55: a byte of 55 goes to HUNTAA; any other byte is dropped.
- HUNTAA: AA goes to LENH and raises oBusy; 55 stays in HUNTAA; any other byte returns to HUNT55.
- LENH/LENL: the 16-bit big-endian length must equal WORDS_PER_FRAME. On mismatch (checked at LENL): error code 1, no RAM writes, return to HUNT55.
- Entering LENH snapshots the frame start: frameBase = current write pointer, chkBase = running checksum.
- DATH latches the high byte. DATL forms the word {hi, lo}, adds it to the running checksum (mod 2^16), and enters WRITE.
- WRITE holds oBlockRAM_WrReq=1 with the address and data stable until iBlockRAM_WrDone. On acknowledge, the write pointer increments; after word WORDS_PER_FRAME go to CHKH, otherwise go to DATH.
- A byte arriving while in WRITE is an overrun: error code 3.
- CHKH/CHKL: compare the received big-endian checksum with the running checksum.
  - Match: oFrameDone, oErrCode=0, good-frame counter +1.
  - Mismatch: error code 2.
- The checksum is cumulative across the block. It is cleared only at block start (reset, iEn low, or after oBlockDone); it is not cleared per frame.
- Any error: pulse oFrameErr, set oErrCode, restore the write pointer to frameBase and the checksum to chkBase, clear oBusy, return to HUNT55.
- Timeout: in any state other than HUNT55/HUNTAA, a gap of TIMEOUT_CYC cycles with no iRxDone gives error code 3. In WRITE the timer is frozen.
- When the good-frame counter reaches FRAMES_PER_BLOCK: pulse oBlockDone in the same cycle as oFrameDone, then reset the write pointer, checksum and counter to 0.

## Timing
- Reset (iRst=1, or iEn=0) values: state HUNT55; oBlockRAM_WrReq 0, oBlockRAM_WrAddr 0, oBlockRAM_WrData 0; oFrameDone, oFrameErr, oBlockDone, oBusy 0; oErrCode 0; checksum, pointer and counters 0.
- Reset mid-write drops oBlockRAM_WrReq the next cycle.
- oBlockRAM_WrReq rises in the cycle after the DATL strobe and falls in the cycle after iBlockRAM_WrDone is sampled high. oBlockRAM_WrAddr and oBlockRAM_WrData do not change while the request is high.
- oFrameDone/oFrameErr/oBlockDone rise in the cycle after the deciding byte's strobe and last exactly one cycle.
- oBusy falls in the same cycle that oFrameDone or oFrameErr rises.
- Pointer width 12 bits. Rollover happens only at the block boundary; 2999+1 never occurs mid-frame, because a 50th frame ends exactly at 2999.

## Test plan
- Frame 55 AA 00 3C, words 0x0000..0x003B, checksum 06 EA -> 60 writes to addr 0..59 with data = addr; oFrameDone=1 for one cycle; oErrCode=0.
- Second frame, all words 0x0001, checksum 07 26 (cumulative 0x06EA+60) -> writes to addr 60..119; accepted. Sending checksum 00 3C instead -> oFrameErr, oErrCode=2; the next good frame writes again at addr 60.
- Length 00 3B -> oFrameErr, oErrCode=1, zero write requests, back in hunt.
- Leading garbage 12 55 55 AA then a valid frame -> frame accepted (the repeated 55 does not lose sync).
- Stop the stream for TIMEOUT_CYC cycles after word 10 -> oFrameErr, oErrCode=3, pointer restored to the frame base. Hold iBlockRAM_WrDone low and send a byte -> overrun, oErrCode=3.
- 50 consecutive good frames -> oBlockDone pulses together with the 50th oFrameDone; the next frame writes at addr 0 and its checksum restarts from 0.

Source files
------------

// File: rtl/zuart_download_ram.sv
// zuart_download_ram: parses framed UART word stream into BlockRAM writes with length/checksum validation
module zuart_download_ram #(
   parameter int WORDS_PER_FRAME  = 60,
   parameter int FRAMES_PER_BLOCK = 50,
   parameter int TIMEOUT_CYC      = 100000
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEn,
   input  logic [7:0]  iRxData,
   input  logic        iRxDone,
   output logic        oBlockRAM_WrReq,
   output logic [11:0] oBlockRAM_WrAddr,
   output logic [15:0] oBlockRAM_WrData,
   input  logic        iBlockRAM_WrDone,
   output logic        oFrameDone,
   output logic        oFrameErr,
   output logic [1:0]  oErrCode,
   output logic        oBlockDone,
   output logic        oBusy
);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);
   localparam int WCW = $clog2(WORDS_PER_FRAME + 1);
   localparam int FCW = $clog2(FRAMES_PER_BLOCK + 1);
   typedef enum logic [3:0] {HUNT55, HUNTAA, LENH, LENL, DATH, DATL, WRITE, CHKH, CHKL} state_t;
   state_t          state_q;
   logic [11:0]     ptr_q, base_q;
   logic [15:0]     chk_q, chk_base_q, wr_data_q;
   logic [7:0]      hi_q;
   logic [WCW-1:0]  wcnt_q;
   logic [FCW-1:0]  frames_q;
   logic [TW-1:0]   timer_q;
   logic            wr_req_q, frame_done_q, frame_err_q, block_done_q, busy_q;
   logic [1:0]      err_q, err_c;
   logic [15:0]     rx_word;
   logic            in_frame, tmo, ovr;
   assign rx_word  = {hi_q, iRxData};
   assign in_frame = !(state_q inside {HUNT55, HUNTAA, WRITE});
   assign tmo      = in_frame && !iRxDone && timer_q == TW'(TIMEOUT_CYC - 1);
   assign ovr      = state_q == WRITE && iRxDone;
   assign err_c    = (tmo || ovr) ? 2'd3 :
                     (iRxDone && state_q == LENL && rx_word != 16'(WORDS_PER_FRAME)) ? 2'd1 :
                     (iRxDone && state_q == CHKL && rx_word != chk_q) ? 2'd2 : 2'd0;
   assign oBlockRAM_WrReq  = wr_req_q;
   assign oBlockRAM_WrAddr = ptr_q;
   assign oBlockRAM_WrData = wr_data_q;
   assign oFrameDone       = frame_done_q;
   assign oFrameErr        = frame_err_q;
   assign oErrCode         = err_q;
   assign oBlockDone       = block_done_q;
   assign oBusy            = busy_q;
   // Frame parser: any error rolls pointer and checksum back to the frame start
   always_ff @(posedge iClk) begin
      if (iRst || !iEn) begin
         state_q <= HUNT55;
         ptr_q <= '0;
         base_q <= '0;
         chk_q <= '0;
         chk_base_q <= '0;
         wr_data_q <= '0;
         hi_q <= '0;
         wcnt_q <= '0;
         frames_q <= '0;
         timer_q <= '0;
         wr_req_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q <= 1'b0;
         block_done_q <= 1'b0;
         busy_q <= 1'b0;
         err_q <= '0;
      end else begin
         frame_done_q <= 1'b0;
         frame_err_q <= 1'b0;
         block_done_q <= 1'b0;
         timer_q <= (iRxDone || state_q inside {HUNT55, HUNTAA}) ? '0 : (state_q == WRITE) ? timer_q : timer_q + 1'b1;
         if (err_c != 2'd0) begin
            frame_err_q <= 1'b1;
            err_q <= err_c;
            ptr_q <= base_q;
            chk_q <= chk_base_q;
            busy_q <= 1'b0;
            wr_req_q <= 1'b0;
            state_q <= HUNT55;
         end else begin
            case (state_q)
               HUNT55: if (iRxDone && iRxData == 8'h55) state_q <= HUNTAA;
               HUNTAA: if (iRxDone) begin
                  if (iRxData == 8'hAA) begin
                     state_q <= LENH;
                     busy_q <= 1'b1;
                     base_q <= ptr_q;
                     chk_base_q <= chk_q;
                     wcnt_q <= '0;
                  end else if (iRxData != 8'h55) state_q <= HUNT55;
               end
               LENH: if (iRxDone) begin
                  hi_q <= iRxData;
                  state_q <= LENL;
               end
               LENL: if (iRxDone) state_q <= DATH;
               DATH: if (iRxDone) begin
                  hi_q <= iRxData;
                  state_q <= DATL;
               end
               DATL: if (iRxDone) begin
                  chk_q <= chk_q + rx_word;
                  wr_data_q <= rx_word;
                  wr_req_q <= 1'b1;
                  state_q <= WRITE;
               end
               WRITE: if (iBlockRAM_WrDone) begin
                  wr_req_q <= 1'b0;
                  ptr_q <= ptr_q + 1'b1;
                  wcnt_q <= wcnt_q + 1'b1;
                  state_q <= (wcnt_q == WCW'(WORDS_PER_FRAME - 1)) ? CHKH : DATH;
               end
               CHKH: if (iRxDone) begin
                  hi_q <= iRxData;
                  state_q <= CHKL;
               end
               CHKL: if (iRxDone) begin
                  frame_done_q <= 1'b1;
                  err_q <= 2'd0;
                  busy_q <= 1'b0;
                  state_q <= HUNT55;
                  if (frames_q == FCW'(FRAMES_PER_BLOCK - 1)) begin
                     block_done_q <= 1'b1;
                     frames_q <= '0;
                     ptr_q <= '0;
                     chk_q <= '0;
                  end else frames_q <= frames_q + 1'b1;
               end
               default: state_q <= HUNT55;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_zuart_download_ram.sv
// tb_zuart_download_ram: randomized frame stimulus checked against a frame-level reference model
module tb_zuart_download_ram;
   localparam int W   = 60;
   localparam int FPB = 50;
   localparam int TMO = 300;
   logic        clk = 0, rst = 1, en = 1, rx_done = 0, wr_done = 0;
   logic [7:0]  rx_data = 0;
   logic        wr_req, fd, fe, bd, busy;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  errc;
   int          checks = 0, errors = 0;
   logic [27:0] wq[$];
   bit          ack_en = 1;
   int          m_ptr = 0, m_frames = 0;
   logic [15:0] m_chk = 0;
   logic [1:0]  m_err = 0;
   logic [15:0] w[W];
   logic        prev_req = 0;
   logic [11:0] pa = 0;
   logic [15:0] pd = 0;

   zuart_download_ram #(.WORDS_PER_FRAME(W), .FRAMES_PER_BLOCK(FPB), .TIMEOUT_CYC(TMO)) dut (
      .iClk(clk), .iRst(rst), .iEn(en), .iRxData(rx_data), .iRxDone(rx_done),
      .oBlockRAM_WrReq(wr_req), .oBlockRAM_WrAddr(wr_addr), .oBlockRAM_WrData(wr_data),
      .iBlockRAM_WrDone(wr_done), .oFrameDone(fd), .oFrameErr(fe), .oErrCode(errc),
      .oBlockDone(bd), .oBusy(busy)
   );

   always #5 clk = ~clk;

   // RAM responder: random-latency acknowledge, logs completed writes, checks request stability
   initial begin
      forever begin
         @(negedge clk);
         if (prev_req && wr_req) begin
            checks++;
            if (wr_addr !== pa || wr_data !== pd) begin
               errors++;
               $display("FAIL wr_stable addr %h was %h data %h was %h", wr_addr, pa, wr_data, pd);
            end
         end
         prev_req = wr_req;
         pa = wr_addr;
         pd = wr_data;
         if (wr_req && ack_en && !wr_done && $urandom_range(0, 2) != 0) begin
            wr_done = 1;
            wq.push_back({wr_addr, wr_data});
         end else wr_done = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_done = 1;
      @(posedge clk);
      #1 rx_done = 0;
   endtask

   task automatic wait_write();
      int n = 0;
      while (wr_req && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL write_ack_wait req still %b after %0d cycles", wr_req, n);
      end
   endtask

   task automatic send_word(input logic [15:0] v);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
      wait_write();
   endtask

   task automatic fill_rand();
      for (int i = 0; i < W; i++) w[i] = 16'($urandom);
   endtask

   task automatic send_frame(input logic [15:0] len, input bit bad_chk, input bit garbage);
      int base = m_ptr;
      int nexp = 0;
      bit blk = 0;
      logic [15:0] sum = m_chk;
      logic [15:0] ck;
      for (int i = 0; i < W; i++) sum = sum + w[i];
      wq.delete();
      if (garbage) begin
         send_byte(8'h12);
         send_byte(8'h55);
      end
      send_byte(8'h55);
      send_byte(8'hAA);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_sync got %b want 1", busy);
      end
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      if (len != 16'(W)) begin
         m_err = 2'd1;
         checks++;
         if ({fd, fe, bd, busy, errc} !== {3'b010, 1'b0, m_err}) begin
            errors++;
            $display("FAIL len_reject done/err/blk/busy/code got %b%b%b%b %0d want 0100 %0d", fd, fe, bd, busy, errc, m_err);
         end
      end else begin
         for (int i = 0; i < W; i++) send_word(w[i]);
         ck = bad_chk ? sum ^ 16'(1 << $urandom_range(0, 15)) : sum;
         send_byte(ck[15:8]);
         send_byte(ck[7:0]);
         nexp = W;
         if (bad_chk) m_err = 2'd2;
         else begin
            m_err = 2'd0;
            m_ptr += W;
            m_chk = sum;
            m_frames++;
            if (m_frames == FPB) begin
               blk = 1;
               m_frames = 0;
               m_ptr = 0;
               m_chk = 0;
            end
         end
         checks++;
         if ({fd, fe, bd, busy, errc} !== {!bad_chk, bad_chk, blk, 1'b0, m_err}) begin
            errors++;
            $display("FAIL frame_end done/err/blk/busy/code got %b%b%b%b %0d want %b%b%b0 %0d", fd, fe, bd, busy, errc, !bad_chk, bad_chk, blk, m_err);
         end
      end
      tick();
      checks++;
      if ({fd, fe, bd} !== 3'b000) begin
         errors++;
         $display("FAIL pulse_width done/err/blk got %b%b%b want 000", fd, fe, bd);
      end
      checks++;
      if (wq.size() != nexp) begin
         errors++;
         $display("FAIL write_count got %0d want %0d", wq.size(), nexp);
      end
      for (int i = 0; i < wq.size() && i < nexp; i++) begin
         checks++;
         if (wq[i] !== {12'(base + i), w[i]}) begin
            errors++;
            $display("FAIL write_%0d addr/data got %h/%h want %h/%h", i, wq[i][27:16], wq[i][15:0], 12'(base + i), w[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) tick();
      checks++;
      if ({wr_req, wr_addr, wr_data, fd, fe, errc, bd, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got req %b addr %h data %h fd %b fe %b code %0d bd %b busy %b want all 0", wr_req, wr_addr, wr_data, fd, fe, errc, bd, busy);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_basic();
      for (int i = 0; i < W; i++) w[i] = 16'(i);
      send_frame(16'(W), 0, 0);
      for (int i = 0; i < W; i++) w[i] = 16'h0001;
      send_frame(16'(W), 1, 0);
      send_frame(16'(W), 0, 0);
      fill_rand();
      send_frame(16'(W), 0, 0);
   endtask

   task automatic test_length();
      fill_rand();
      send_frame(16'h003B, 0, 0);
      send_frame(16'h013C, 0, 0);
      send_frame(16'(W), 0, 0);
   endtask

   task automatic test_garbage();
      fill_rand();
      send_frame(16'(W), 0, 1);
   endtask

   task automatic test_timeout();
      int n = 0;
      fill_rand();
      send_byte(8'h55);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'(W));
      for (int i = 0; i < 10; i++) send_word(w[i]);
      while (!fe && n < TMO + 20) begin
         tick();
         n++;
      end
      m_err = 2'd3;
      checks++;
      if (fe !== 1'b1 || errc !== m_err || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err fe %b code %0d busy %b want 1 %0d 0", fe, errc, busy, m_err);
      end
      checks++;
      if (n < TMO - 5 || n > TMO + 5) begin
         errors++;
         $display("FAIL timeout_delay got %0d cycles want about %0d", n, TMO);
      end
      fill_rand();
      send_frame(16'(W), 0, 0);
   endtask

   task automatic test_overrun();
      fill_rand();
      ack_en = 0;
      send_byte(8'h55);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'(W));
      send_byte(w[0][15:8]);
      send_byte(w[0][7:0]);
      repeat (3) tick();
      checks++;
      if (wr_req !== 1'b1) begin
         errors++;
         $display("FAIL req_held got %b want 1", wr_req);
      end
      send_byte(8'h5A);
      m_err = 2'd3;
      checks++;
      if (fe !== 1'b1 || errc !== m_err || wr_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL overrun fe %b code %0d req %b busy %b want 1 %0d 0 0", fe, errc, wr_req, busy, m_err);
      end
      ack_en = 1;
      send_frame(16'(W), 0, 0);
   endtask

   task automatic test_soft_reset();
      fill_rand();
      send_byte(8'h55);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'(W));
      for (int i = 0; i < 3; i++) send_word(w[i]);
      ack_en = 0;
      send_byte(w[3][15:8]);
      send_byte(w[3][7:0]);
      en = 0;
      tick();
      checks++;
      if ({wr_req, wr_addr, busy, errc, fd, fe} !== '0) begin
         errors++;
         $display("FAIL soft_reset req %b addr %h busy %b code %0d fd %b fe %b want all 0", wr_req, wr_addr, busy, errc, fd, fe);
      end
      en = 1;
      ack_en = 1;
      m_ptr = 0;
      m_chk = 0;
      m_frames = 0;
      m_err = 0;
      tick();
   endtask

   task automatic test_block();
      for (int f = 0; f < FPB; f++) begin
         fill_rand();
         send_frame(16'(W), 0, 0);
      end
      fill_rand();
      send_frame(16'(W), 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_length();
      test_garbage();
      test_timeout();
      test_overrun();
      test_soft_reset();
      test_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
